// File: rtl/cbm2_bus_sched_if.sv
// cbm2_bus_sched_if: request inputs and access strobes of the CBM-II bus scheduler
// master: the scheduler (reads model/steal/pause/dma_req, drives phase and strobes)
// slave : bus decode/mux, cores and DMA requester (the other side)
interface cbm2_bus_sched_if;
    logic model;
    logic steal;
    logic pause;
    logic dma_req;
    logic phase;
    logic vidCycle;
    logic cpuCycle;
    logic dmaCycle;
    logic dma_ack;
    logic cpu_ce;
    logic vid_ce;
    logic cpu_stalled;
    modport master (
        input  model, steal, pause, dma_req,
        output phase, vidCycle, cpuCycle, dmaCycle, dma_ack, cpu_ce, vid_ce, cpu_stalled
    );
    modport slave (
        output model, steal, pause, dma_req,
        input  phase, vidCycle, cpuCycle, dmaCycle, dma_ack, cpu_ce, vid_ce, cpu_stalled
    );
endinterface

// File: rtl/cbm2_bus_sched.sv
// cbm2_bus_sched: time-division video/CPU/DMA scheduler for the CBM-II system bus
// clk_sys, reset : system clock, asynchronous active-high reset
// bus (master)   : model/steal/pause/dma_req in; phase, *Cycle strobes, dma_ack,
//                  cpu_ce, vid_ce, cpu_stalled out (all registered)
module cbm2_bus_sched #(
    parameter int HALF    = 16,
    parameter int ACC_LEN = 4
) (
    input  logic clk_sys,
    input  logic reset,
    cbm2_bus_sched_if.master bus
);
    localparam int W = $clog2(HALF);
    localparam logic [W-1:0] LAST   = W'(HALF - 1);
    localparam logic [W-1:0] ACC    = W'(ACC_LEN);
    localparam logic [W-1:0] ACK_AT = W'(ACC_LEN + 1);
    localparam logic [1:0] NONE = 2'd0, VID = 2'd1, CPU = 2'd2, DMA = 2'd3;

    if (HALF < ACC_LEN + 3) begin : g_param_chk
        $error("cbm2_bus_sched: HALF must be >= ACC_LEN+3");
    end

    logic [W-1:0] cnt_q, cnt_d;
    logic         phase_q, phase_d;
    logic [1:0]   own_q, own_d, sel;
    logic         acc, stall_d;
    logic         vid_q, cpu_q, dma_q, ack_q, cpu_ce_q, vid_ce_q, stall_q;

    // Outputs are registered from the next state, so each strobe lines up
    // with the cnt value it is decoded for.
    always_comb begin
        sel     = !phase_q ? VID :
                  (bus.steal && !bus.model) ? VID :
                  bus.dma_req ? DMA :
                  !bus.pause ? CPU : NONE;
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        phase_d = (cnt_q == LAST) ? ~phase_q : phase_q;
        // owner is latched while leaving cnt 0 and held for the rest of the half
        own_d   = (cnt_q == '0) ? sel : own_q;
        acc     = (cnt_d != '0) && (cnt_d <= ACC);
        stall_d = (phase_d && cnt_d == LAST) ? (own_d != CPU) : stall_q;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            own_q    <= NONE;
            vid_q    <= 1'b0;
            cpu_q    <= 1'b0;
            dma_q    <= 1'b0;
            ack_q    <= 1'b0;
            cpu_ce_q <= 1'b0;
            vid_ce_q <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            own_q    <= own_d;
            vid_q    <= acc && own_d == VID;
            cpu_q    <= acc && own_d == CPU;
            dma_q    <= acc && own_d == DMA;
            ack_q    <= cnt_d == ACK_AT && own_d == DMA;
            cpu_ce_q <= phase_d && cnt_d == LAST && own_d == CPU;
            vid_ce_q <= !phase_d && cnt_d == LAST;
            stall_q  <= stall_d;
        end
    end

    assign bus.phase       = phase_q;
    assign bus.vidCycle    = vid_q;
    assign bus.cpuCycle    = cpu_q;
    assign bus.dmaCycle    = dma_q;
    assign bus.dma_ack     = ack_q;
    assign bus.cpu_ce      = cpu_ce_q;
    assign bus.vid_ce      = vid_ce_q;
    assign bus.cpu_stalled = stall_q;
endmodule

// File: tb/tb_cbm2_bus_sched.sv
// tb_cbm2_bus_sched: directed half-by-half check of cbm2_bus_sched (HALF=16, ACC_LEN=4)
module tb_cbm2_bus_sched;
    localparam logic [1:0] NONE = 2'd0, VID = 2'd1, CPU = 2'd2, DMA = 2'd3;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    int   errs    = 0;
    int   checks  = 0;
    string step   = "init";

    cbm2_bus_sched_if bus();

    cbm2_bus_sched #(.HALF(16), .ACC_LEN(4)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] o;
    assign o = {bus.phase, bus.vidCycle, bus.cpuCycle, bus.dmaCycle,
                bus.dma_ack, bus.cpu_ce, bus.vid_ce, bus.cpu_stalled};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Checks one half (cnt 0..15) against a hand-chosen owner; leaves us at cnt 0 of the next half.
    // Vector order: phase vid cpu dma ack cpu_ce vid_ce stalled.
    task automatic run_half(input logic ph, input logic [1:0] own, input logic st0);
        for (int k = 0; k < 16; k++) begin
            logic [7:0] e;
            logic a;
            a = (k >= 1) && (k <= 4);
            e = {ph, a && own == VID, a && own == CPU, a && own == DMA,
                 k == 5 && own == DMA, ph && k == 15 && own == CPU, !ph && k == 15,
                 (ph && k == 15) ? (own != CPU) : st0};
            chk($sformatf("%s ph%0d cnt%0d", step, ph, k), o, e);
            tick();
        end
    endtask

    initial begin
        bus.model   = 1'b0;
        bus.steal   = 1'b0;
        bus.pause   = 1'b0;
        bus.dma_req = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("reset outputs", o, 8'h00);
        reset = 1'b0;

        step = "normal";
        run_half(0, VID, 0);
        run_half(1, CPU, 0);

        step = "steal";
        bus.steal = 1'b1;
        run_half(0, VID, 0);
        run_half(1, VID, 0);
        bus.steal = 1'b0;
        run_half(0, VID, 1);
        run_half(1, CPU, 1);

        step = "steal model1";
        bus.model = 1'b1;
        bus.steal = 1'b1;
        run_half(0, VID, 0);
        run_half(1, CPU, 0);
        bus.model = 1'b0;
        bus.steal = 1'b0;

        step = "dma x3";
        bus.dma_req = 1'b1;
        run_half(0, VID, 0);
        run_half(1, DMA, 0);
        run_half(0, VID, 1);
        run_half(1, DMA, 1);
        run_half(0, VID, 1);
        run_half(1, DMA, 1);
        bus.dma_req = 1'b0;
        run_half(0, VID, 1);
        run_half(1, CPU, 1);

        step = "steal+dma";
        bus.steal   = 1'b1;
        bus.dma_req = 1'b1;
        run_half(0, VID, 0);
        run_half(1, VID, 0);
        bus.steal = 1'b0;
        run_half(0, VID, 1);
        run_half(1, DMA, 1);
        bus.dma_req = 1'b0;
        run_half(0, VID, 1);
        run_half(1, CPU, 1);

        step = "pause";
        bus.pause = 1'b1;
        run_half(0, VID, 0);
        run_half(1, NONE, 0);
        bus.dma_req = 1'b1;
        run_half(0, VID, 1);
        run_half(1, DMA, 1);
        bus.dma_req = 1'b0;
        bus.pause   = 1'b0;
        run_half(0, VID, 1);
        run_half(1, CPU, 1);

        step = "reset mid dma";
        bus.dma_req = 1'b1;
        run_half(0, VID, 0);
        tick();
        tick();
        chk("dma cnt2 before reset", o, 8'b1001_0000);
        #2 reset = 1'b1;
        #1 chk("async reset same clock", o, 8'h00);
        bus.dma_req = 1'b0;
        tick();
        chk("held in reset", o, 8'h00);
        reset = 1'b0;
        step = "after reset";
        run_half(0, VID, 0);
        run_half(1, CPU, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
